// File: rtl/core_fetch_queue.sv
// core_fetch_queue: prefetch parcel buffer between the icache read port and
// the IF stage. It issues sequential word reads, stores the returned data as
// 16-bit parcels, and presents IF with a 32-bit window at its PC, along with a
// flag that says whether that window holds a complete instruction. A PC
// discontinuity from IF is treated as a redirect: the buffer is flushed and
// responses that are still in flight are discarded.
//
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   o_req_valid/o_req_addr      icache word read request (addr[1:0] == 0)
//   i_req_ready                 icache accepts the request this cycle
//   i_rsp_valid/i_rsp_data      in-order read response, little-endian parcels
//   i_rsp_err                   response is an access fault
//   i_fetch_addr                IF PC (2-byte aligned)
//   o_fetch_data                {parcel1, parcel0} at head, 0 where absent
//   o_fetch_ready               complete instruction available at i_fetch_addr
//   o_fetch_fault               fetch at head faulted
//   i_consume                   IF takes the instruction (only when ready)
//   i_stall                     freezes consumption and redirect detection
module core_fetch_queue #(
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [63:0] RESET_PC        = 64'h0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  output logic        o_req_valid,
  output logic [63:0] o_req_addr,
  input  logic        i_req_ready,
  input  logic        i_rsp_valid,
  input  logic [31:0] i_rsp_data,
  input  logic        i_rsp_err,
  input  logic [63:0] i_fetch_addr,
  output logic [31:0] o_fetch_data,
  output logic        o_fetch_ready,
  output logic        o_fetch_fault,
  input  logic        i_consume,
  input  logic        i_stall
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic          started_q, started_d;
  logic [63:0]   head_pc_q, head_pc_d;
  logic [63:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] drop_q, drop_d;
  logic          skip_low_q, skip_low_d;
  logic          fault_q, fault_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]   mem_q [DEPTH];

  logic [15:0]   parcel0, parcel1;
  logic          ins32, at_head, redirect, have_insn;
  logic          req_valid, fire, take, rsp_live;
  logic [31:0]   count_w, out_w, push_n, pop_n;
  logic          wr0_en, wr1_en;
  logic [PW-1:0] wr0_idx, wr1_idx;
  logic [15:0]   wr0_data, wr1_data;

  // Head window, request gating and FIFO datapath.
  always_comb begin
    count_w   = 32'(count_q);
    out_w     = 32'(outstanding_q);
    parcel0   = (count_w >= 32'd1) ? mem_q[rd_ptr_q] : '0;
    parcel1   = (count_w >= 32'd2) ? mem_q[rd_ptr_q + PW'(1)] : '0;
    ins32     = (parcel0[1:0] == 2'b11);
    at_head   = (i_fetch_addr == head_pc_q);
    // started_q keeps every output low until the first clock after reset.
    redirect  = started_q && !i_stall && !at_head;
    have_insn = (count_w >= 32'd2) || ((count_w == 32'd1) && !ins32);

    o_fetch_ready = started_q && at_head && !i_stall && have_insn;
    o_fetch_fault = started_q && fault_q && at_head &&
                    ((count_w == 32'd0) || ((count_w == 32'd1) && ins32));
    o_fetch_data  = {parcel1, parcel0};

    // Reserve two parcels for every response still in flight, dropped ones
    // included, so a push can never overflow the FIFO.
    req_valid   = started_q && !fault_q && (out_w < MAX_OUTSTANDING) &&
                  (count_w + 32'd2 * out_w + 32'd2 <= DEPTH) && !redirect;
    o_req_valid = req_valid;
    o_req_addr  = req_pc_q;
    fire        = req_valid && i_req_ready;

    take  = i_consume && o_fetch_ready;
    pop_n = take ? (ins32 ? 32'd2 : 32'd1) : 32'd0;

    // Once faulted, later responses belong to a path IF can never reach
    // without a redirect, so they are discarded like the faulting one.
    rsp_live = started_q && i_rsp_valid && !redirect && (drop_q == '0) &&
               !i_rsp_err && !fault_q;

    wr0_idx  = wr_ptr_q;
    wr1_idx  = wr_ptr_q + PW'(1);
    wr0_data = skip_low_q ? i_rsp_data[31:16] : i_rsp_data[15:0];
    wr1_data = i_rsp_data[31:16];
    wr0_en   = rsp_live;
    wr1_en   = rsp_live && !skip_low_q;
    push_n   = rsp_live ? (skip_low_q ? 32'd1 : 32'd2) : 32'd0;
  end

  // Next-state logic.
  always_comb begin
    started_d     = 1'b1;
    head_pc_d     = head_pc_q;
    req_pc_d      = req_pc_q;
    count_d       = count_q;
    outstanding_d = OW'(out_w + (fire ? 32'd1 : 32'd0) - (i_rsp_valid ? 32'd1 : 32'd0));
    drop_d        = drop_q;
    skip_low_d    = skip_low_q;
    fault_d       = fault_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect) begin
      // Everything already requested, including a response arriving right
      // now, belongs to the old path.
      head_pc_d  = i_fetch_addr;
      req_pc_d   = {i_fetch_addr[63:2], 2'b00};
      skip_low_d = i_fetch_addr[1];
      fault_d    = 1'b0;
      count_d    = '0;
      wr_ptr_d   = rd_ptr_q;
      drop_d     = OW'(out_w - (i_rsp_valid ? 32'd1 : 32'd0));
    end else begin
      if (fire) begin
        req_pc_d = req_pc_q + 64'd4;
      end
      if (i_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - OW'(1);
        end else if (i_rsp_err) begin
          fault_d = 1'b1;
        end else if (rsp_live && skip_low_q) begin
          skip_low_d = 1'b0;
        end
      end
      if (take) begin
        head_pc_d = head_pc_q + (ins32 ? 64'd4 : 64'd2);
      end
      rd_ptr_d = rd_ptr_q + PW'(pop_n);
      wr_ptr_d = wr_ptr_q + PW'(push_n);
      count_d  = CW'(count_w + push_n - pop_n);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      started_q     <= 1'b0;
      head_pc_q     <= RESET_PC;
      req_pc_q      <= {RESET_PC[63:2], 2'b00};
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      skip_low_q    <= RESET_PC[1];
      fault_q       <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      started_q     <= started_d;
      head_pc_q     <= head_pc_d;
      req_pc_q      <= req_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      skip_low_q    <= skip_low_d;
      fault_q       <= fault_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Parcel storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge i_clk) begin
    if (wr0_en) mem_q[wr0_idx] <= wr0_data;
    if (wr1_en) mem_q[wr1_idx] <= wr1_data;
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (count_w + push_n <= DEPTH + pop_n));

endmodule

// File: tb/tb_core_fetch_queue.sv
module tb_core_fetch_queue;

  logic        i_clk;
  logic        i_reset_n;
  logic        o_req_valid;
  logic [63:0] o_req_addr;
  logic        i_req_ready;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic        i_rsp_err;
  logic [63:0] i_fetch_addr;
  logic [31:0] o_fetch_data;
  logic        o_fetch_ready;
  logic        o_fetch_fault;
  logic        i_consume;
  logic        i_stall;

  core_fetch_queue #(.DEPTH(8), .MAX_OUTSTANDING(2), .RESET_PC(64'h0)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .o_req_valid(o_req_valid), .o_req_addr(o_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .i_fetch_addr(i_fetch_addr), .o_fetch_data(o_fetch_data),
    .o_fetch_ready(o_fetch_ready), .o_fetch_fault(o_fetch_fault),
    .i_consume(i_consume), .i_stall(i_stall)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
    bit          is32;
    int          grp;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  int errors = 0;
  int checks = 0;
  int cyc;
  int lat = 1;
  int fires = 0;
  int first_ready_cyc = -1;
  bit seen24 = 0;
  logic [63:0] if_pc = 64'h0;

  logic [31:0] imem [logic [63:0]];
  bit          err_at [logic [63:0]];
  pend_t       pend[$];
  logic [63:0] exp_req[$];
  vec_t        exp_fetch[$];
  vec_t        vt[6];

  always @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(logic [63:0] a);
    if (imem.exists(a)) return imem[a];
    return 32'h00000013;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One clock: sample at the falling edge, act on the rising edge, drive
  // inputs 1 time unit later, return 1 unit after that.
  task automatic tick();
    bit          consumed;
    int          adv;
    vec_t        v;
    pend_t       p;
    logic [63:0] e;
    consumed = 0;
    adv = 0;
    @(negedge i_clk);
    if (o_req_valid && i_req_ready) begin
      pend.push_back('{addr: o_req_addr, due: cyc + lat});
      fires++;
      if (o_req_addr == 64'h24) seen24 = 1;
      if (exp_req.size() > 0) begin
        e = exp_req.pop_front();
        check("req_addr", o_req_addr, e);
      end
    end
    if (!i_stall && exp_fetch.size() > 0 && exp_fetch[0].pc == if_pc && o_fetch_ready) begin
      v = exp_fetch.pop_front();
      if (v.is32) check("fetch_data32", {32'h0, o_fetch_data}, {32'h0, v.data});
      else        check("fetch_data16", {48'h0, o_fetch_data[15:0]}, {48'h0, v.data[15:0]});
      if (first_ready_cyc < 0) first_ready_cyc = cyc;
      consumed = 1;
      adv = v.is32 ? 4 : 2;
    end
    i_consume = consumed;
    @(posedge i_clk);
    #1;
    i_consume = 1'b0;
    if (consumed) if_pc = if_pc + 64'(adv);
    if (!i_stall && exp_fetch.size() > 0 && exp_fetch[0].pc != if_pc) if_pc = exp_fetch[0].pc;
    i_fetch_addr = if_pc;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      i_rsp_valid = 1'b1;
      i_rsp_data  = mem_word(p.addr);
      i_rsp_err   = err_at.exists(p.addr);
    end else begin
      i_rsp_valid = 1'b0;
      i_rsp_data  = '0;
      i_rsp_err   = 1'b0;
    end
    #1;
  endtask

  task automatic run_until_empty(string name, int budget);
    int n;
    n = 0;
    while (exp_fetch.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_fetch.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d fetches left, want 0", name, exp_fetch.size());
      exp_fetch.delete();
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_req_valid"}, {63'h0, o_req_valid}, 64'h0);
    check({tag, "_req_addr"}, o_req_addr, 64'h0);
    check({tag, "_fetch_ready"}, {63'h0, o_fetch_ready}, 64'h0);
    check({tag, "_fetch_fault"}, {63'h0, o_fetch_fault}, 64'h0);
    check({tag, "_fetch_data"}, {32'h0, o_fetch_data}, 64'h0);
  endtask

  initial begin
    int  f0;
    bit  got;

    vt[0] = '{pc: 64'h0,   data: 32'h00000013, is32: 1, grp: 0};
    vt[1] = '{pc: 64'h4,   data: 32'h00A00093, is32: 1, grp: 0};
    vt[2] = '{pc: 64'h100, data: 32'h00004501, is32: 0, grp: 1};
    vt[3] = '{pc: 64'h102, data: 32'h00004501, is32: 0, grp: 1};
    vt[4] = '{pc: 64'h104, data: 32'h00000013, is32: 1, grp: 1};
    vt[5] = '{pc: 64'h13E, data: 32'h00A00093, is32: 1, grp: 2};

    imem[64'h0]    = 32'h00000013;
    imem[64'h4]    = 32'h00A00093;
    imem[64'h100]  = 32'h45014501;
    imem[64'h104]  = 32'h00000013;
    imem[64'h13C]  = 32'h0093ABCD;
    imem[64'h140]  = 32'h5A5A00A0;
    imem[64'h20]   = 32'h11111111;
    imem[64'h24]   = 32'h22222223;
    imem[64'h8000] = 32'h00300093;
    imem[64'h8004] = 32'h00400093;
    imem[64'h3C]   = 32'h00000013;
    imem[64'h200]  = 32'h00500093;
    err_at[64'h40] = 1;

    i_reset_n = 1'b0; i_req_ready = 1'b1; i_rsp_valid = 1'b0; i_rsp_data = '0;
    i_rsp_err = 1'b0; i_fetch_addr = '0; i_consume = 1'b0; i_stall = 1'b0;

    // Reset state, then the gap between release and the first clock.
    repeat (2) @(negedge i_clk);
    check_reset_outputs("reset");
    #1 i_reset_n = 1'b1;
    #1 check("post_release_req_valid", {63'h0, o_req_valid}, 64'h0);

    // Table-driven sequential, mixed RVC and straddling fetches.
    exp_req.push_back(64'h0);
    exp_req.push_back(64'h4);
    exp_req.push_back(64'h8);
    for (int g = 0; g < 3; g++) begin
      foreach (vt[i]) if (vt[i].grp == g) exp_fetch.push_back(vt[i]);
      run_until_empty("table", 60);
      if (g == 0) check("first_ready_cycle", 64'(first_ready_cyc), 64'd3);
    end
    exp_req.delete();

    // Redirect with two responses in flight: both must be discarded.
    repeat (15) tick();
    lat = 3;
    seen24 = 0;
    if_pc = 64'h20;
    i_fetch_addr = if_pc;
    for (int k = 0; k < 12 && !seen24; k++) tick();
    check("drop_seen_req24", {63'h0, seen24}, 64'h1);
    if_pc = 64'h8000;
    i_fetch_addr = if_pc;
    exp_req.push_back(64'h8000);
    exp_fetch.push_back('{pc: 64'h8000, data: 32'h00300093, is32: 1, grp: 3});
    exp_fetch.push_back('{pc: 64'h8004, data: 32'h00400093, is32: 1, grp: 3});
    run_until_empty("drop", 60);
    exp_req.delete();

    // Access fault at 0x40, then a redirect clears it.
    lat = 1;
    exp_fetch.push_back('{pc: 64'h3C, data: 32'h00000013, is32: 1, grp: 4});
    run_until_empty("pre_fault", 40);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = o_fetch_fault;
    end
    check("fault_seen", {63'h0, got}, 64'h1);
    f0 = fires;
    repeat (6) tick();
    check("fault_req_stop", 64'(fires - f0), 64'h0);
    check("fault_held", {63'h0, o_fetch_fault}, 64'h1);
    check("fault_ready_low", {63'h0, o_fetch_ready}, 64'h0);
    exp_fetch.push_back('{pc: 64'h200, data: 32'h00500093, is32: 1, grp: 5});
    run_until_empty("fault_recover", 40);
    check("fault_cleared", {63'h0, o_fetch_fault}, 64'h0);

    // Stalled fill to capacity, then one 32-bit consume reopens requests.
    if_pc = 64'h300;
    i_fetch_addr = if_pc;
    tick();
    i_stall = 1'b1;
    f0 = fires;
    repeat (20) tick();
    check("full_words_requested", 64'(fires - f0), 64'd4);
    check("full_req_valid", {63'h0, o_req_valid}, 64'h0);
    check("stall_ready_low", {63'h0, o_fetch_ready}, 64'h0);
    i_stall = 1'b0;
    exp_req.push_back(64'h310);
    exp_fetch.push_back('{pc: 64'h300, data: 32'h00000013, is32: 1, grp: 6});
    run_until_empty("full_consume", 20);
    for (int k = 0; k < 6 && exp_req.size() > 0; k++) tick();
    check("refill_req_pending", 64'(exp_req.size()), 64'h0);
    exp_req.delete();

    // Reset in the middle of a request burst.
    if_pc = 64'h400;
    i_fetch_addr = if_pc;
    repeat (3) tick();
    #2 i_reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    pend.delete();
    i_rsp_valid = 1'b0; i_rsp_data = '0; i_rsp_err = 1'b0;
    if_pc = 64'h0;
    i_fetch_addr = if_pc;
    repeat (2) @(negedge i_clk);
    #1 i_reset_n = 1'b1;
    exp_req.push_back(64'h0);
    exp_fetch.push_back('{pc: 64'h0, data: 32'h00000013, is32: 1, grp: 7});
    run_until_empty("restart", 30);
    check("restart_req_pending", 64'(exp_req.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
